// File: rtl/bp_pkg.sv
// Shared branch-predictor types: RV32 opcode/funct3 decode constants, BTB entry layout, mispredict codes.
// Pure definitions; no timing or flow-control behaviour.
package bp_pkg;

   localparam int BP_ENTRIES = 32;
   localparam int BP_XLEN    = 32;
   localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
   localparam int BP_TAG_W   = BP_XLEN - BP_IDX_W - 2;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      logic [BP_XLEN-1:0]  target;
      logic [1:0]          ctr;
   } btb_entry_t;

   typedef enum logic [1:0] {
      MP_NONE      = 2'b00,
      MP_NOT_TAKEN = 2'b01,
      MP_TAKEN     = 2'b10
   } mispredict_e;

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

endpackage

// File: rtl/bp_resolve.sv
// Decides whether the EX instruction is a control transfer and whether it is actually taken.
// Purely combinational, zero latency; no flow control.
module bp_resolve
   import bp_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       br_eq,
   input  logic       br_lt,
   output logic       is_ctrl,
   output logic       taken,
   output logic       is_jump
);

   always_comb begin
      is_ctrl = 1'b0;
      taken   = 1'b0;
      is_jump = 1'b0;
      case (opcode)
         OP_BRANCH: begin
            case (funct3)
               F3_BEQ:          begin is_ctrl = 1'b1; taken = br_eq;  end
               F3_BNE:          begin is_ctrl = 1'b1; taken = ~br_eq; end
               F3_BLT, F3_BLTU: begin is_ctrl = 1'b1; taken = br_lt;  end
               F3_BGE, F3_BGEU: begin is_ctrl = 1'b1; taken = ~br_lt; end
               default: ;
            endcase
         end
         OP_JAL, OP_JALR: begin
            is_ctrl = 1'b1;
            taken   = 1'b1;
            is_jump = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/btb_bht_predictor.sv
// Direct-mapped BTB, optional 2-bit direction counters (BP_BHT_EN), plus mispredict statistics.
// Lookup and mispredict combinational; updates land on the next edge; no backpressure, one resolution per cycle.
module btb_bht_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES = BP_ENTRIES,
   parameter int XLEN    = BP_XLEN
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            hit_o,
   output logic            taken_o,
   output logic [XLEN-1:0] predicted_pc_o,
   input  logic            ex_valid_i,
   input  logic [31:0]     inst_ex_i,
   input  logic [XLEN-1:0] pc_ex_i,
   input  logic [XLEN-1:0] target_ex_i,
   input  logic            br_eq_i,
   input  logic            br_lt_i,
   input  logic            pred_taken_ex_i,
   input  logic [XLEN-1:0] pred_pc_ex_i,
   output logic [1:0]      mispredict_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic [31:0]     br_cnt_o,
   output logic [31:0]     miss_cnt_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem [ENTRIES];
   logic [XLEN-1:0]    tgt_mem [ENTRIES];
`ifdef BP_BHT_EN
   logic [1:0]         ctr_mem [ENTRIES];
`endif

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             lk_hit, ex_hit;
   logic             is_ctrl, act_taken, is_jump, qual;
   mispredict_e      mp;
   logic             unused_bits;

   assign unused_bits = ^{inst_ex_i[31:15], inst_ex_i[11:7], pc_i[1:0]};

   assign if_idx = pc_i[IDX_W+1:2];
   assign if_tag = pc_i[XLEN-1:IDX_W+2];
   assign ex_idx = pc_ex_i[IDX_W+1:2];
   assign ex_tag = pc_ex_i[XLEN-1:IDX_W+2];

   assign lk_hit = valid[if_idx] && (tag_mem[if_idx] == if_tag);
   assign ex_hit = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);

   assign hit_o = ~rst_i & lk_hit;
`ifdef BP_BHT_EN
   assign taken_o = hit_o & ctr_mem[if_idx][1];
`else
   assign taken_o = hit_o;
`endif
   assign predicted_pc_o = taken_o ? tgt_mem[if_idx] : '0;

   bp_resolve u_resolve (
      .opcode  (inst_ex_i[6:0]),
      .funct3  (inst_ex_i[14:12]),
      .br_eq   (br_eq_i),
      .br_lt   (br_lt_i),
      .is_ctrl (is_ctrl),
      .taken   (act_taken),
      .is_jump (is_jump)
   );

   assign qual = ex_valid_i & ~rst_i & is_ctrl;

   always_comb begin
      mp = MP_NONE;
      if (qual) begin
         if (pred_taken_ex_i && !act_taken)
            mp = MP_NOT_TAKEN;
         else if (act_taken && (!pred_taken_ex_i || (pred_pc_ex_i != target_ex_i)))
            mp = MP_TAKEN;
      end
   end

   assign mispredict_o  = mp;
   assign redirect_pc_o = (mp == MP_NOT_TAKEN) ? pc_ex_i + XLEN'(4) :
                          (mp == MP_TAKEN)     ? target_ex_i : '0;

   // Tag/target arrays need no reset: valid bits gate every use of them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid      <= '0;
         br_cnt_o   <= '0;
         miss_cnt_o <= '0;
`ifdef BP_BHT_EN
         for (int i = 0; i < ENTRIES; i++) ctr_mem[i] <= 2'b00;
`endif
      end else if (qual) begin
         br_cnt_o <= br_cnt_o + 32'd1;
         if (mp != MP_NONE) miss_cnt_o <= miss_cnt_o + 32'd1;
         if (act_taken) begin
            valid[ex_idx]   <= 1'b1;
            tag_mem[ex_idx] <= ex_tag;
            tgt_mem[ex_idx] <= target_ex_i;
`ifdef BP_BHT_EN
            ctr_mem[ex_idx] <= is_jump ? 2'b11 :
                               ex_hit  ? ctr_inc(ctr_mem[ex_idx]) : 2'b10;
`endif
         end
`ifdef BP_BHT_EN
         else if (ex_hit) begin
            ctr_mem[ex_idx] <= ctr_dec(ctr_mem[ex_idx]);
         end
`endif
      end
   end

endmodule
